// File: rtl/ofdm_cp_remover.sv
// ---------------------------------------------------------------------------
// ofdm_cp_remover
//   Receive-side cyclic-prefix stripper. Consumes a continuous stream of
//   complex time-domain samples, CP+N beats per OFDM symbol. It drops the
//   first CP beats and forwards the N body beats through a single output
//   register to the FFT. tlast marks the last body beat of each symbol.
//   tuser carries the symbol index, modulo 256.
//
// Optional feature (compile-time macro OFDM_CP_RESYNC_EN):
//   When defined, s_axis_tlast is honoured. An accepted beat that carries
//   tlast before the expected symbol end restarts framing at CP sample 0.
//   The symbol index advances and err_sync pulses for one cycle. When the
//   macro is undefined, s_axis_tlast is ignored and err_sync stays 0.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/   input sample stream ([31:16] re, [15:0] im)
//   tlast/tready
//   m_axis_tdata/tvalid/   body sample stream to the FFT
//   tlast/tuser/tready
//   err_sync               one-cycle framing-mismatch pulse
// ---------------------------------------------------------------------------
module ofdm_cp_remover #(
    parameter int N  = 32,
    parameter int CP = 16,
    parameter int DW = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    output logic [7:0]    m_axis_tuser,
    input  logic          m_axis_tready,
    output logic          err_sync
);
    localparam int TOT = CP + N;
    localparam int CW  = $clog2(TOT);
    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_CP_LAST  = CW'(CP - 1);
    localparam logic [CW-1:0] CNT_SYM_LAST = CW'(TOT - 1);

    typedef enum logic [0:0] {
        ST_SKIP = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] samp_cnt_q, samp_cnt_d;
    logic [7:0]    sym_idx_q, sym_idx_d;
    logic [DW-1:0] tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic [7:0]    tuser_q, tuser_d;
    logic          err_q, err_d;

    logic          accept_s;
    logic          out_fire_s;
    logic          resync_s;
    logic          sym_end_s;

    // Input ready: CP beats are always drained; body beats need room in the output register
    always_comb begin
        if (state_q == ST_PASS) begin
            s_axis_tready = !tvalid_q || m_axis_tready;
        end else begin
            s_axis_tready = 1'b1;
        end
    end

    assign accept_s   = s_axis_tvalid && s_axis_tready;
    assign out_fire_s = tvalid_q && m_axis_tready;

`ifdef OFDM_CP_RESYNC_EN
    // An early tlast truncates the current symbol; a missing tlast is ignored.
    assign resync_s = accept_s && s_axis_tlast && (samp_cnt_q != CNT_SYM_LAST);
`else
    logic unused_tlast_s;
    assign unused_tlast_s = s_axis_tlast;
    assign resync_s       = 1'b0;
`endif

    assign sym_end_s = resync_s || (samp_cnt_q == CNT_SYM_LAST);

    // Next-state, counter and output-register load logic
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        sym_idx_d  = sym_idx_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        err_d      = resync_s;
        if (out_fire_s) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        case (state_q)
            ST_SKIP: begin
                if (accept_s) begin
                    if (resync_s) begin
                        samp_cnt_d = CNT_ZERO;
                        sym_idx_d  = sym_idx_q + 8'd1;
                    end else if (samp_cnt_q == CNT_CP_LAST) begin
                        samp_cnt_d = samp_cnt_q + CNT_ONE;
                        state_d    = ST_PASS;
                    end else begin
                        samp_cnt_d = samp_cnt_q + CNT_ONE;
                    end
                end else begin
                    samp_cnt_d = samp_cnt_q;
                end
            end
            ST_PASS: begin
                if (accept_s) begin
                    // A load overrides the clear above, so a simultaneous
                    // transfer and accept keeps tvalid high.
                    tvalid_d = 1'b1;
                    tdata_d  = s_axis_tdata;
                    tuser_d  = sym_idx_q;
                    tlast_d  = sym_end_s;
                    if (sym_end_s) begin
                        samp_cnt_d = CNT_ZERO;
                        sym_idx_d  = sym_idx_q + 8'd1;
                        state_d    = ST_SKIP;
                    end else begin
                        samp_cnt_d = samp_cnt_q + CNT_ONE;
                    end
                end else begin
                    samp_cnt_d = samp_cnt_q;
                end
            end
            default: begin
                state_d    = ST_SKIP;
                samp_cnt_d = CNT_ZERO;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_SKIP;
            samp_cnt_q <= CNT_ZERO;
            sym_idx_q  <= 8'd0;
            tdata_q    <= {DW{1'b0}};
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            sym_idx_q  <= sym_idx_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            err_q      <= err_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign err_sync      = err_q;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
module tb_ofdm_cp_remover;
    localparam int N   = 32;
    localparam int CP  = 16;
    localparam int TOT = CP + N;
`ifdef OFDM_CP_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tuser;
    logic        m_axis_tready;
    logic        err_sync;

    ofdm_cp_remover #(.N(N), .CP(CP), .DW(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .err_sync      (err_sync)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [7:0]  u;
    } out_t;

    typedef struct {
        int ready_mode;   // 0: always 1, 1: 1 on / 2 off, 2: random
        int vpct;         // input valid probability in percent
        int nsym;         // symbols driven (CP+N beats each)
        int tl_beat;      // beat carrying s_axis_tlast, -1 for none
        bit rand_data;    // random sample data instead of beat number
        int exp_beats;
        int exp_lasts;
        int exp_errs;
    } scen_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rmode = 0;
    int    m_pos = 0;
    int    m_sym = 0;
    int    err_seen = 0;
    logic  exp_err = 1'b0;
    logic  prev_stall = 1'b0;
    logic  prev_body = 1'b0;
    out_t  prev_out;
    out_t  exp_q[$];
    out_t  coll[$];
    scen_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: position of each accepted beat within its symbol.
    task automatic model_accept(input logic [31:0] d, input logic l);
        bit   rs;
        out_t e;
        rs = RESYNC && l && (m_pos != TOT - 1);
        prev_body = (m_pos >= CP);
        if (m_pos >= CP) begin
            e.d = d;
            e.l = (m_pos == TOT - 1) || rs;
            e.u = 8'(m_sym % 256);
            exp_q.push_back(e);
        end
        if ((m_pos == TOT - 1) || rs) begin
            m_pos = 0;
            m_sym++;
        end else begin
            m_pos++;
        end
        exp_err = rs;
    endtask

    // One clock: drive at the falling edge, sample 1 ns later.
    task automatic step(input logic v, input logic [31:0] d, input logic l, output logic acc);
        out_t e;
        @(negedge aclk);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        case (rmode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ((cyc % 3) == 0);
            default: m_axis_tready = 1'($urandom_range(1));
        endcase
        #1;
        chk("err_sync", {63'd0, err_sync}, {63'd0, exp_err});
        if (err_sync) err_seen++;
        if (prev_body) chk("latency_valid", {63'd0, m_axis_tvalid}, 64'd1);
        if (prev_stall) begin
            chk("hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
            chk("hold_data", {23'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata},
                {23'd0, prev_out.l, prev_out.u, prev_out.d});
        end
        if (v && (m_pos < CP)) chk("cp_no_stall", {63'd0, s_axis_tready}, 64'd1);
        acc = v && s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", {23'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata},
                    {23'd0, e.l, e.u, e.d});
            end
            e.d = m_axis_tdata; e.l = m_axis_tlast; e.u = m_axis_tuser;
            coll.push_back(e);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out.d = m_axis_tdata; prev_out.l = m_axis_tlast; prev_out.u = m_axis_tuser;
        if (acc) begin
            model_accept(d, l);
        end else begin
            exp_err   = 1'b0;
            prev_body = 1'b0;
        end
        cyc++;
    endtask

    task automatic apply_reset(input bit check_drop);
        @(negedge aclk);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #1;
        if (check_drop) chk("reset_drops_valid", {63'd0, m_axis_tvalid}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        exp_q.delete();
        m_pos = 0; m_sym = 0;
        exp_err = 1'b0; prev_stall = 1'b0; prev_body = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        rmode = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b0, acc);
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Back-to-back beats, data = base + beat number, ready held high.
    task automatic drive_beats(input int n, input int base);
        logic acc;
        int   k;
        int   guard;
        k = 0; guard = 0;
        rmode = 0;
        while (k < n && guard < 1000) begin
            step(1'b1, 32'(base + k), 1'b0, acc);
            if (acc) k++;
            guard++;
        end
        if (k < n) chk("drive_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic        v, acc, tl;
        logic [31:0] cur_d;
        int          beat, guard, bad, first_bad, lasts;

        tbl[0] = '{0, 100,   3, -1, 1'b0,   96,   3, 0};
        tbl[1] = '{1, 100,   3, -1, 1'b0,   96,   3, 0};
        tbl[2] = '{0,  50, 300, -1, 1'b0, 9600, 300, 0};
        tbl[3] = '{2,  70,  20, -1, 1'b1,  640,  20, 0};
`ifdef OFDM_CP_RESYNC_EN
        tbl[4] = '{0, 100,   3, 40, 1'b0,   89,   3, 1};
`else
        tbl[4] = '{0, 100,   3, 40, 1'b0,   96,   3, 0};
`endif

        aresetn = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 32'd0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_tdata",  {32'd0, m_axis_tdata}, 64'd0);
        chk("rst_tlast",  {63'd0, m_axis_tlast}, 64'd0);
        chk("rst_tuser",  {56'd0, m_axis_tuser}, 64'd0);
        chk("rst_err",    {63'd0, err_sync}, 64'd0);

        for (int s = 0; s < 5; s++) begin
            apply_reset(1'b0);
            coll.delete();
            err_seen = 0;
            rmode = tbl[s].ready_mode;
            beat = 0; guard = 0; v = 1'b0;
            cur_d = tbl[s].rand_data ? $urandom : 32'd0;
            while (beat < tbl[s].nsym * TOT) begin
                if (!v) v = ($urandom_range(99) < tbl[s].vpct);
                tl = v && (beat == tbl[s].tl_beat);
                step(v, v ? cur_d : 32'd0, tl, acc);
                if (acc) begin
                    beat++;
                    v = 1'b0;
                    cur_d = tbl[s].rand_data ? $urandom : 32'(beat);
                end
                guard++;
                if (guard > 60000) begin
                    chk($sformatf("s%0d_timeout", s), 64'd1, 64'd0);
                    break;
                end
            end
            drain();
            lasts = 0;
            foreach (coll[i]) if (coll[i].l) lasts++;
            chk($sformatf("s%0d_beats", s), 64'(coll.size()), 64'(tbl[s].exp_beats));
            chk($sformatf("s%0d_lasts", s), 64'(lasts), 64'(tbl[s].exp_lasts));
            chk($sformatf("s%0d_errs", s), 64'(err_seen), 64'(tbl[s].exp_errs));
            // Direct arithmetic framing check when data = beat number and no truncation.
            if (!tbl[s].rand_data && (tbl[s].exp_errs == 0)) begin
                bad = 0; first_bad = -1;
                foreach (coll[i]) begin
                    if (coll[i].d !== 32'(16 + (i / 32) * 48 + (i % 32)) ||
                        coll[i].l !== ((i % 32) == 31) ||
                        coll[i].u !== 8'((i / 32) % 256)) begin
                        bad++;
                        if (first_bad < 0) first_bad = i;
                    end
                end
                chk($sformatf("s%0d_framing_badidx%0d", s, first_bad), 64'(bad), 64'd0);
            end
            if (s == 2 && coll.size() > 256 * 32) begin
                chk("tuser_255", {56'd0, coll[255 * 32].u}, 64'd255);
                chk("tuser_wrap", {56'd0, coll[256 * 32].u}, 64'd0);
            end
            if (s == 4 && RESYNC && coll.size() > 25) begin
                chk("trunc_last", {31'd0, coll[24].l, coll[24].d}, {31'd0, 1'b1, 32'd40});
                chk("sym1_start", {24'd0, coll[25].u, coll[25].d}, {24'd0, 8'd1, 32'd57});
            end
        end

        // Reset mid-symbol: after body beat 10 of symbol 1 (beat 74).
        apply_reset(1'b0);
        drive_beats(TOT + CP + 11, 0);
        apply_reset(1'b1);
        coll.delete();
        drive_beats(TOT, 1000);
        drain();
        chk("rst_mid_beats", 64'(coll.size()), 64'd32);
        if (coll.size() == 32) begin
            chk("rst_mid_first", {24'd0, coll[0].u, coll[0].d}, {24'd0, 8'd0, 32'd1016});
            chk("rst_mid_last", {31'd0, coll[31].l, coll[31].d}, {31'd0, 1'b1, 32'd1047});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofdm_cp_remover.md
# ofdm_cp_remover

Receive-side cyclic-prefix stripper for the 16-QAM, N=32, CP=16 OFDM chain. Consumes a continuous AXI4-Stream of complex time-domain samples (48 beats per symbol: 16 CP + 32 body). Discards the CP and forwards the 32 body samples to the forward-FFT core as a framed stream: `tlast` on sample 31, symbol index on `tuser`. It is the receive-end counterpart of the transmit IFFT/CP-insertion path and feeds the FFT data slave port directly.

## Interface
- `N`, 32, FFT size / body samples per symbol (power of two, 8..256)
- `CP`, 16, cyclic-prefix samples per symbol (1..N)
- `DW`, 32, sample width: [31:16] real, [15:0] imaginary, two's complement
- `aclk`  in  1  clock
- `aresetn`  in  1  reset; asynchronous, active-low
- `s_axis_tdata`  in  DW  received time-domain sample
- `s_axis_tvalid`  in  1  input sample valid
- `s_axis_tlast`  in  1  symbol-boundary marker; used only with `OFDM_CP_RESYNC_EN`
- `s_axis_tready`  out  1  input accept
- `m_axis_tdata`  out  DW  body sample to the FFT
- `m_axis_tvalid`  out  1  output valid
- `m_axis_tlast`  out  1  last body sample of a symbol
- `m_axis_tuser`  out  8  symbol index, modulo 256
- `m_axis_tready`  in  1  FFT accepts sample
- `err_sync`  out  1  one-cycle pulse on a detected framing mismatch

## Operation
- Input beat accepted when `s_axis_tvalid && s_axis_tready`. Output beat transfers when `m_axis_tvalid && m_axis_tready`.
- `samp_cnt`, log2(CP+N) bits, counts accepted input beats per symbol, range 0..CP+N-1. Wraps to 0 after CP+N-1.
- FSM:
  - SKIP: `samp_cnt` < CP. Beats are accepted and dropped. `s_axis_tready`=1 regardless of output state. On the accept with `samp_cnt`==CP-1, go to PASS.
  - PASS: `samp_cnt` in CP..CP+N-1. Each accepted beat is loaded into the output register.
    - `m_axis_tlast` = (`samp_cnt`==CP+N-1).
    - `m_axis_tuser` = `sym_idx`.
    - On the accept with `samp_cnt`==CP+N-1: `sym_idx` increments (wraps 255→0) and the FSM goes to SKIP.
- Output register: a single stage.
  - In PASS, `s_axis_tready` = `!m_axis_tvalid || m_axis_tready` (combinational).
  - `m_axis_tvalid` sets on a PASS accept. It clears on an output transfer with no simultaneous PASS accept.
  - On a simultaneous output transfer and PASS accept, the register reloads and `m_axis_tvalid` stays 1.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tuser` hold stable.
- Sample data passes unmodified. No arithmetic is applied to the samples.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `err_sync`=0.
  - FSM=SKIP, `samp_cnt`=0, `sym_idx`=0.
  - `s_axis_tready`=1 while in reset is allowed, but no beat is accepted while `aresetn`=0.
- Latency: input accept to `m_axis_tvalid` is 1 cycle.
- Throughput: 1 beat/cycle with `m_axis_tready` held at 1. Output duty cycle is N/(CP+N) = 32 of every 48 input cycles.
- Back-pressure stalls input only in PASS. CP beats are always drained, even while the output is stalled.
- Reset mid-symbol: the partial symbol is lost, including any held output beat. The next accepted beat is CP sample 0.
- `s_axis_tvalid` low: counters hold. Gaps do not affect framing.

## Configuration
- `OFDM_CP_RESYNC_EN` defined: `s_axis_tlast` is honored.
  - An accepted beat with `s_axis_tlast`=1 and `samp_cnt`≠CP+N-1 forces `samp_cnt`→0 and FSM→SKIP for the next beat, and increments `sym_idx`.
  - `err_sync` pulses high for 1 cycle, in the cycle after that accept.
  - If that beat was in PASS, it is forwarded with `m_axis_tlast`=1 (truncated symbol).
  - A missing `s_axis_tlast` at CP+N-1 raises no error and triggers no action.
- `OFDM_CP_RESYNC_EN` undefined: `s_axis_tlast` is ignored, `err_sync` is tied 0, and framing is purely count-based.

## Test plan
- Reset, then 3 symbols of 48 beats with tdata = beat number 0..143 and `m_axis_tready`=1.
  - Required output: 96 beats, with tdata 16..47, 64..95, 112..143.
  - `m_axis_tlast` on tdata 47, 95 and 143.
  - `m_axis_tuser` = 0, 1, 2 per symbol.
- Same stimulus with `m_axis_tready` toggling 1 cycle on / 2 cycles off.
  - Identical output sequence.
  - No output beat dropped or duplicated.
  - CP beats accepted without stalls.
  - Output held stable while stalled.
- Random `s_axis_tvalid` gaps (50%) over 300 symbols.
  - Every symbol yields exactly 32 beats.
  - `m_axis_tuser` wraps 255→0 at symbol 256.
- Assert `aresetn`=0 for 1 cycle after body beat 10 of symbol 1.
  - `m_axis_tvalid` drops to 0 immediately.
  - The next 48 input beats produce 32 outputs starting from input beat 16 after reset, with `m_axis_tuser`=0.
- With `OFDM_CP_RESYNC_EN` defined: drive `s_axis_tlast` on beat 40 of symbol 0.
  - Output tlast on body sample 24.
  - `err_sync` pulses once.
  - Symbol 1 body starts 16 beats after beat 40, with `m_axis_tuser`=1.
- Without the macro: same stimulus.
  - `s_axis_tlast` is ignored.
  - `err_sync` stays 0.
  - Framing is identical to the first scenario.
